// File: rtl/vdic_mult_seq.sv
// Sequential radix-2 shift-add multiplier with per-operand parity checking,
// runtime signed/unsigned mode and a req/ack/result_rdy handshake.
module vdic_mult_seq #(
  parameter int unsigned DATA_W     = 16,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     arg_a,
  input  logic                  arg_a_parity,
  input  logic [DATA_W-1:0]     arg_b,
  input  logic                  arg_b_parity,
  input  logic                  signed_mode,
  input  logic                  req,
  output logic                  ack,
  output logic                  busy,
  output logic [2*DATA_W-1:0]   result,
  output logic                  result_parity,
  output logic                  result_rdy,
  output logic                  arg_parity_error
);

  localparam int unsigned CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic                neg_q, neg_d;
  logic                err_q, err_d;
  logic                ack_q, ack_d;
  logic                busy_q, busy_d;
  logic                rdy_q, rdy_d;
  logic [2*DATA_W-1:0] res_q, res_d;
  logic                rpar_q, rpar_d;
  logic                perr_q, perr_d;

  logic [DATA_W-1:0]   mag_a, mag_b;
  logic                ok_a, ok_b;
  logic [DATA_W:0]     sum;
  logic [2*DATA_W-1:0] prod;

  // Magnitudes are taken at acceptance so later operand changes cannot leak in.
  assign mag_a = (signed_mode && arg_a[DATA_W-1]) ? -arg_a : arg_a;
  assign mag_b = (signed_mode && arg_b[DATA_W-1]) ? -arg_b : arg_b;
  assign ok_a  = ((^{arg_a, arg_a_parity}) == PARITY_ODD);
  assign ok_b  = ((^{arg_b, arg_b_parity}) == PARITY_ODD);
  assign sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, mcand_q};
  assign prod  = neg_q ? -acc_q : acc_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    err_d   = err_q;
    ack_d   = 1'b0;
    busy_d  = busy_q;
    rdy_d   = 1'b0;
    res_d   = res_q;
    rpar_d  = rpar_q;
    perr_d  = perr_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          ack_d   = 1'b1;
          busy_d  = 1'b1;
          mcand_d = mag_a;
          acc_d   = {{DATA_W{1'b0}}, mag_b};
          neg_d   = signed_mode & (arg_a[DATA_W-1] ^ arg_b[DATA_W-1]);
          err_d   = !(ok_a && ok_b);
          cnt_d   = CW'(DATA_W);
          state_d = (ok_a && ok_b) ? S_CALC : S_DONE;
        end
      end
      S_CALC: begin
        // Multiplier sits in the low half and is consumed as the product shifts in.
        if (acc_q[0]) acc_d = {sum, acc_q[DATA_W-1:1]};
        else          acc_d = {1'b0, acc_q[2*DATA_W-1:1]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        rdy_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (err_q) begin
          res_d  = '0;
          perr_d = 1'b1;
          rpar_d = PARITY_ODD;
        end else begin
          res_d  = prod;
          perr_d = 1'b0;
          rpar_d = (^prod) ^ PARITY_ODD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
      res_q   <= '0;
      rpar_q  <= PARITY_ODD;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      res_q   <= res_d;
      rpar_q  <= rpar_d;
      perr_q  <= perr_d;
    end
  end

  assign ack              = ack_q;
  assign busy             = busy_q;
  assign result           = res_q;
  assign result_parity    = rpar_q;
  assign result_rdy       = rdy_q;
  assign arg_parity_error = perr_q;

endmodule

// File: tb/tb_vdic_mult_seq.sv
// Scoreboard bench: stimulus pushes expected responses, per-instance monitors
// pop and compare on result_rdy. Covers 16-bit even and 8-bit odd instances.
module tb_vdic_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        par;
    logic        err;
    int          lat;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done16 = 0, done8 = 0;
  int   ackc16 = 0, ackc8 = 0;

  // 16-bit, even parity instance
  logic        rst16, ap16, bp16, sm16, req16;
  logic [15:0] a16, b16;
  logic        ack16, busy16, par16, rdy16, err16;
  logic [31:0] res16;

  vdic_mult_seq #(.DATA_W(16), .PARITY_ODD(1'b0)) u16 (
    .clk(clk), .rst(rst16), .arg_a(a16), .arg_a_parity(ap16), .arg_b(b16),
    .arg_b_parity(bp16), .signed_mode(sm16), .req(req16), .ack(ack16),
    .busy(busy16), .result(res16), .result_parity(par16), .result_rdy(rdy16),
    .arg_parity_error(err16)
  );

  // 8-bit, odd parity instance
  logic        rst8, ap8, bp8, sm8, req8;
  logic [7:0]  a8, b8;
  logic        ack8, busy8, par8, rdy8, err8;
  logic [15:0] res8;

  vdic_mult_seq #(.DATA_W(8), .PARITY_ODD(1'b1)) u8 (
    .clk(clk), .rst(rst8), .arg_a(a8), .arg_a_parity(ap8), .arg_b(b8),
    .arg_b_parity(bp8), .signed_mode(sm8), .req(req8), .ack(ack8),
    .busy(busy8), .result(res8), .result_parity(par8), .result_rdy(rdy8),
    .arg_parity_error(err8)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ack16) ackc16 = cyc;
    if (rdy16) begin
      chk("rdy16_expected", 32'(q16.size() != 0), 32'd1);
      if (q16.size() != 0) begin
        e = q16.pop_front();
        chk("res16", res16, e.res);
        chk("par16", 32'(par16), 32'(e.par));
        chk("err16", 32'(err16), 32'(e.err));
        chk("lat16", 32'(cyc - ackc16), 32'(e.lat));
        chk("busy16_at_rdy", 32'(busy16), 32'd0);
      end
      done16++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ack8) ackc8 = cyc;
    if (rdy8) begin
      chk("rdy8_expected", 32'(q8.size() != 0), 32'd1);
      if (q8.size() != 0) begin
        e = q8.pop_front();
        chk("res8", 32'(res8), e.res);
        chk("par8", 32'(par8), 32'(e.par));
        chk("err8", 32'(err8), 32'(e.err));
        chk("lat8", 32'(cyc - ackc8), 32'(e.lat));
        chk("busy8_at_rdy", 32'(busy8), 32'd0);
      end
      done8++;
    end
  end

  // pulse_busy: inject a req pulse with different operands while the op is in flight
  task automatic issue(input bit d8, input logic [15:0] a, input logic ap,
                       input logic [15:0] b, input logic bp, input logic sm,
                       input logic [31:0] er, input logic ep, input logic ee,
                       input bit pulse_busy);
    exp_t e;
    int   base, n;
    logic seen;
    e.res = er; e.par = ep; e.err = ee;
    e.lat = ee ? 1 : (d8 ? 9 : 17);
    @(negedge clk);
    if (d8) begin
      q8.push_back(e); base = done8;
      a8 = a[7:0]; ap8 = ap; b8 = b[7:0]; bp8 = bp; sm8 = sm; req8 = 1'b1;
    end else begin
      q16.push_back(e); base = done16;
      a16 = a; ap16 = ap; b16 = b; bp16 = bp; sm16 = sm; req16 = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clk); n++;
      seen = d8 ? ack8 : ack16;
    end while (!seen && n < 10);
    chk(d8 ? "ack8_seen" : "ack16_seen", 32'(seen), 32'd1);
    // Scramble inputs after acceptance; the operation in flight must ignore them.
    if (d8) begin
      req8 = 1'b0; a8 = ~a8; b8 = ~b8; sm8 = ~sm8;
    end else begin
      req16 = 1'b0; a16 = ~a16; b16 = ~b16; sm16 = ~sm16;
    end
    if (pulse_busy && d8) begin
      repeat (3) @(negedge clk);
      a8 = 8'h11; ap8 = 1'b1; b8 = 8'h03; bp8 = 1'b1; req8 = 1'b1;
      @(negedge clk);
      req8 = 1'b0;
    end
    n = 0;
    while ((d8 ? done8 : done16) == base && n < 40) begin
      @(negedge clk); n++;
    end
    chk(d8 ? "rdy8_seen" : "rdy16_seen", 32'((d8 ? done8 : done16) != base), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst16 = 1'b1; rst8 = 1'b1;
    req16 = 1'b0; a16 = '0; b16 = '0; ap16 = 1'b0; bp16 = 1'b0; sm16 = 1'b0;
    req8  = 1'b0; a8  = '0; b8  = '0; ap8  = 1'b0; bp8  = 1'b0; sm8  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst16_ack", 32'(ack16), 32'd0);
    chk("rst16_busy", 32'(busy16), 32'd0);
    chk("rst16_rdy", 32'(rdy16), 32'd0);
    chk("rst16_res", res16, 32'd0);
    chk("rst16_par", 32'(par16), 32'd0);
    chk("rst16_err", 32'(err16), 32'd0);
    chk("rst8_par", 32'(par8), 32'd1);
    chk("rst8_res", 32'(res8), 32'd0);
    rst16 = 1'b0; rst8 = 1'b0;

    // 16-bit even parity
    issue(0, 16'h0003, 0, 16'h0005, 0, 0, 32'd15,        0, 0, 0);
    issue(0, 16'h8000, 1, 16'h8000, 1, 1, 32'h40000000,  1, 0, 0);
    issue(0, 16'hFFFF, 0, 16'h0001, 1, 1, 32'hFFFFFFFF,  0, 0, 0);
    issue(0, 16'h0000, 0, 16'h8000, 1, 1, 32'h00000000,  0, 0, 0);
    issue(0, 16'hFFFF, 0, 16'hFFFF, 0, 0, 32'hFFFE0001,  0, 0, 0);
    issue(0, 16'hFFFD, 1, 16'h0005, 0, 1, 32'hFFFFFFF1,  1, 0, 0);
    issue(0, 16'h8000, 1, 16'h7FFF, 1, 1, 32'hC0008000,  1, 0, 0);
    issue(0, 16'h0003, 0, 16'h0005, 1, 0, 32'd0,         0, 1, 0);
    issue(0, 16'h0003, 1, 16'h0005, 0, 0, 32'd0,         0, 1, 0);
    issue(0, 16'h0003, 1, 16'h0005, 1, 0, 32'd0,         0, 1, 0);
    issue(0, 16'h1234, 1, 16'h0010, 1, 0, 32'h00012340,  1, 0, 0);

    // Reset at E8 of a valid operation: no result may appear for it
    @(negedge clk);
    a16 = 16'h0007; ap16 = 1'b1; b16 = 16'h0009; bp16 = 1'b0; sm16 = 1'b0; req16 = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ack16 && n < 10);
    chk("ack16_before_reset", 32'(ack16), 32'd1);
    req16 = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst16 = 1'b1;
    #1;
    chk("midrst_ack", 32'(ack16), 32'd0);
    chk("midrst_busy", 32'(busy16), 32'd0);
    chk("midrst_rdy", 32'(rdy16), 32'd0);
    chk("midrst_res", res16, 32'd0);
    chk("midrst_par", 32'(par16), 32'd0);
    chk("midrst_err", 32'(err16), 32'd0);
    repeat (2) @(negedge clk);
    rst16 = 1'b0;
    repeat (25) @(negedge clk);
    issue(0, 16'h0003, 0, 16'h0005, 0, 0, 32'd15,        0, 0, 0);

    // 8-bit odd parity
    issue(1, 16'h007F, 0, 16'h0002, 0, 0, 32'h000000FE,  0, 0, 1);
    repeat (15) @(negedge clk);
    issue(1, 16'h0080, 0, 16'h0080, 0, 1, 32'h00004000,  0, 0, 0);
    issue(1, 16'h00FF, 1, 16'h0080, 0, 1, 32'h00000080,  0, 0, 0);
    issue(1, 16'h00FF, 1, 16'h00FF, 1, 0, 32'h0000FE01,  1, 0, 0);
    issue(1, 16'h007F, 1, 16'h0002, 0, 0, 32'd0,         1, 1, 0);

    repeat (5) @(negedge clk);
    chk("q16_drained", 32'(q16.size()), 32'd0);
    chk("q8_drained", 32'(q8.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
